// File: rtl/demux8_rr_sched.sv
// Round-robin scheduler driving a registered 1:8 demultiplexer.
// One input stream is granted to one ready lane for up to BURST beats, then priority rotates past that lane.
module demux8_rr_sched #(
  parameter int DW    = 1,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  input  logic [7:0]      dst_ready,
  output logic [2:0]      sel,
  output logic [7:0]      out_valid,
  output logic [8*DW-1:0] out_bus,
  output logic            busy
);

  localparam int            CW   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [2:0]      sel_reg, sel_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      ov_reg, ov_next;
  logic [8*DW-1:0] bus_reg, bus_next;

  logic [15:0]     ready_dbl;
  logic [7:0]      ready_rot;
  logic [2:0]      offset;
  logic [2:0]      pick;
  logic            sel_ready;
  logic            xfer;
  logic [8*DW-1:0] lane_bus;

  // Rotating the ready vector by ptr turns the circular search into a plain lowest-bit search.
  assign ready_dbl = {dst_ready, dst_ready};
  assign ready_rot = ready_dbl[ptr_reg +: 8];

  always_comb begin
    offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ready_rot[i]) offset = 3'(i);
    end
  end

  assign pick      = ptr_reg + offset;
  assign sel_ready = dst_ready[sel_reg];
  assign in_ready  = (state_reg == GRANT) && sel_ready;
  assign xfer      = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_bus[gi*DW +: DW] = (sel_reg == 3'(gi)) ? in_data : '0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    ov_next    = 8'd0;
    bus_next   = bus_reg;
    case (state_reg)
      IDLE: begin
        if (|dst_ready) begin
          sel_next   = pick;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!sel_ready) begin
          state_next = IDLE;
          ptr_next   = sel_reg + 3'd1;
        end else if (xfer) begin
          ov_next  = 8'd1 << sel_reg;
          bus_next = lane_bus;
          if (cnt_reg == LAST) begin
            state_next = IDLE;
            ptr_next   = sel_reg + 3'd1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      sel_reg   <= 3'd0;
      cnt_reg   <= '0;
      ov_reg    <= 8'd0;
      bus_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      ov_reg    <= ov_next;
      bus_reg   <= bus_next;
    end
  end

  assign sel       = sel_reg;
  assign out_valid = ov_reg;
  assign out_bus   = bus_reg;
  assign busy      = (state_reg == GRANT);

endmodule

// File: tb/tb_demux8_rr_sched.sv
// Randomized bench for demux8_rr_sched: a grant-level model predicts deliveries into a queue,
// and an independent monitor matches every out_valid strobe against that queue.
module tb_demux8_rr_sched;

  localparam int DW    = 4;
  localparam int BURST = 4;
  localparam int NCYC  = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [7:0]      dst_ready;
  logic [2:0]      sel;
  logic [7:0]      out_valid;
  logic [8*DW-1:0] out_bus;
  logic            busy;

  demux8_rr_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dst_ready(dst_ready), .sel(sel), .out_valid(out_valid), .out_bus(out_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t            q[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc   = 0;
  logic [8*DW-1:0] last_bus = '0;

  // Model of the grant: which lane owns the stream, beats delivered so far, next search start.
  bit              m_granted;
  int              m_lane, m_beats, m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_granted = 0;
    m_lane    = 0;
    m_beats   = 0;
    m_ptr     = 0;
    last_bus  = '0;
    q.delete();
  endtask

  // Monitor: after each rising edge, pair any strobe with the oldest prediction.
  initial begin
    exp_t            e;
    logic [8*DW-1:0] eb;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) continue;
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("late_strobe", 64'(out_valid), 64'(8'd1 << e.lane));
      end
      if (out_valid != 8'd0) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e  = q.pop_front();
          eb = '0;
          eb[e.lane*DW +: DW] = e.data;
          chk("out_valid", 64'(out_valid), 64'(8'd1 << e.lane));
          chk("out_bus", 64'(out_bus), 64'(eb));
          last_bus = eb;
        end else begin
          chk("unexpected_strobe", 64'(out_valid), 64'd0);
        end
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("missing_strobe", 64'(out_valid), 64'(8'd1 << e.lane));
        end
        chk("out_bus_hold", 64'(out_bus), 64'(last_bus));
      end
    end
  end

  // Stimulus and reference model, stepped once per cycle on the falling edge.
  initial begin
    int resets = 0;
    bit rdy;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    dst_ready = 8'd0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_bus", 64'(out_bus), 64'd0);
    chk("reset_sel", 64'(sel), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      if (n > 0) @(negedge clk);

      // Asynchronous reset in the middle of a burst, after its first beat has landed.
      if (resets < 3 && n > 400 * (resets + 1) && m_granted && m_beats == 1) begin
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_bus", 64'(out_bus), 64'd0);
        chk("async_rst_sel", 64'(sel), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        model_reset();
        resets++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end

      if (n < 200) begin
        dst_ready = 8'hFF;
        in_valid  = 1'b1;
      end else begin
        case ($urandom_range(15))
          0:       dst_ready = 8'd0;
          1, 2, 3: dst_ready = 8'($urandom);
          4:       dst_ready = 8'd1 << $urandom_range(7);
          5:       dst_ready = dst_ready & ~(8'd1 << m_lane);
          default: ;
        endcase
        in_valid = ($urandom_range(9) < 8);
      end
      in_data = DW'($urandom);
      #1;

      chk("sel", 64'(sel), 64'(m_lane));
      chk("busy", 64'(busy), 64'(m_granted));
      chk("in_ready", 64'(in_ready), 64'(m_granted && dst_ready[m_lane]));

      if (!m_granted) begin
        if (dst_ready != 8'd0) begin
          for (int k = 0; k < 8; k++) begin
            if (dst_ready[(m_ptr + k) % 8]) begin
              m_lane = (m_ptr + k) % 8;
              break;
            end
          end
          m_granted = 1;
          m_beats   = 0;
        end
      end else begin
        rdy = dst_ready[m_lane];
        if (!rdy) begin
          m_granted = 0;
          m_ptr     = (m_lane + 1) % 8;
        end else if (in_valid) begin
          q.push_back('{lane: m_lane, data: in_data, due: cyc + 1});
          m_beats++;
          if (m_beats == BURST) begin
            m_granted = 0;
            m_ptr     = (m_lane + 1) % 8;
          end
        end
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("reset_count", 64'(resets), 64'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
